// File: rtl/dlx_program_loader_pkg.sv
// rtl/dlx_program_loader_pkg.sv - shared constants, state encoding and count check for the program loader
package dlx_program_loader_pkg;

   localparam logic [7:0] HDR_LOAD = 8'hA5;
   localparam logic [7:0] CMD_RUN  = 8'h5A;
   localparam logic [7:0] CMD_STOP = 8'h3C;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DATA  = 2'd2,
      CHECK = 2'd3
   } state_t;

   // A frame must carry at least one word and no more than the memory holds.
   function automatic logic count_ok(input logic [7:0] n, input int unsigned depth);
      return (n != 8'd0) && (32'(n) <= depth);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte gap watchdog: loadable down-counter with clear and expiry flag
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // Reloaded whenever a byte arrives or the loader is idle, so the count measures one gap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear || !run) begin
         cnt_q <= LIMIT;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expire = run && !clear && (cnt_q == '0);

endmodule

// File: rtl/dlx_program_loader.sv
// rtl/dlx_program_loader.sv - parses host load/run/stop frames from the UART and writes DLX instruction memory
module dlx_program_loader
   import dlx_program_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              enable,
   output logic              ack_valid,
   output logic [7:0]        ack_data,
   output logic              load_err
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   state_t            state_q, state_d;
   logic              enable_q, enable_d;
   logic              load_err_q, load_err_d;
   logic              ack_valid_q, ack_valid_d;
   logic [7:0]        ack_data_q, ack_data_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic [7:0]        n_q, n_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        chk_q, chk_d;
   logic [23:0]       asm_q, asm_d;
   logic              expire;
   logic              give_ack;
   logic              give_nak;

   loader_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clear (rx_valid),
      .run   (state_q != IDLE),
      .expire(expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         enable_q     <= 1'b0;
         load_err_q   <= 1'b0;
         ack_valid_q  <= 1'b0;
         ack_data_q   <= 8'h00;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'h0;
         n_q          <= 8'h00;
         word_cnt_q   <= 8'h00;
         byte_idx_q   <= 2'd0;
         chk_q        <= 8'h00;
         asm_q        <= 24'h0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         load_err_q   <= load_err_d;
         ack_valid_q  <= ack_valid_d;
         ack_data_q   <= ack_data_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         n_q          <= n_d;
         word_cnt_q   <= word_cnt_d;
         byte_idx_q   <= byte_idx_d;
         chk_q        <= chk_d;
         asm_q        <= asm_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      enable_d     = enable_q;
      load_err_d   = load_err_q;
      ack_valid_d  = 1'b0;
      ack_data_d   = ack_data_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      n_d          = n_q;
      word_cnt_d   = word_cnt_q;
      byte_idx_d   = byte_idx_q;
      chk_d        = chk_q;
      asm_d        = asm_q;
      give_ack     = 1'b0;
      give_nak     = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  HDR_LOAD: begin
                     enable_d   = 1'b0;
                     load_err_d = 1'b0;
                     state_d    = COUNT;
                  end
                  CMD_RUN:  enable_d = 1'b1;
                  CMD_STOP: enable_d = 1'b0;
                  default: ;
               endcase
            end
         end
         COUNT: begin
            if (rx_valid) begin
               if (count_ok(rx_data, DEPTH)) begin
                  n_d        = rx_data;
                  word_cnt_d = 8'h00;
                  byte_idx_d = 2'd0;
                  chk_d      = 8'h00;
                  asm_d      = 24'h0;
                  state_d    = DATA;
               end else begin
                  give_nak = 1'b1;
               end
            end else if (expire) begin
               give_nak = 1'b1;
            end
         end
         DATA: begin
            // Run/stop codes are plain payload here; only position in the frame matters.
            if (rx_valid) begin
               chk_d      = chk_q ^ rx_data;
               asm_d      = {asm_q[15:0], rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_wdata_d = {asm_q, rx_data};
                  imem_addr_d  = ADDR_W'(word_cnt_q);
                  word_cnt_d   = word_cnt_q + 8'd1;
                  if (word_cnt_q + 8'd1 == n_q) begin
                     state_d = CHECK;
                  end
               end
            end else if (expire) begin
               give_nak = 1'b1;
            end
         end
         CHECK: begin
            if (rx_valid) begin
               if (rx_data == chk_q) begin
                  give_ack = 1'b1;
               end else begin
                  give_nak = 1'b1;
               end
            end else if (expire) begin
               give_nak = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (give_ack) begin
         ack_valid_d = 1'b1;
         ack_data_d  = ACK;
         enable_d    = 1'b1;
         state_d     = IDLE;
      end
      // Already-written words stay in memory; the host is expected to reload after a NAK.
      if (give_nak) begin
         ack_valid_d = 1'b1;
         ack_data_d  = NAK;
         load_err_d  = 1'b1;
         state_d     = IDLE;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign enable     = enable_q;
   assign ack_valid  = ack_valid_q;
   assign ack_data   = ack_data_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_dlx_program_loader.sv
// tb/tb_dlx_program_loader.sv - directed bench for dlx_program_loader
module tb_dlx_program_loader;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned TMO    = 100;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              enable;
   logic              ack_valid;
   logic [7:0]        ack_data;
   logic              load_err;

   int checks = 0;
   int errors = 0;
   int ack_count = 0;
   int we_count = 0;

   always #5 clk = ~clk;

   dlx_program_loader #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .enable    (enable),
      .ack_valid (ack_valid),
      .ack_data  (ack_data),
      .load_err  (load_err)
   );

   always @(negedge clk) begin
      if (ack_valid) ack_count++;
      if (imem_we) we_count++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reply(input string tag, input logic [7:0] code);
      check({tag, "_ack_valid"}, 32'(ack_valid), 32'd1);
      check({tag, "_ack_data"}, 32'(ack_data), 32'(code));
   endtask

   function automatic logic [31:0] pattern(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, b + 8'h11, 8'hC3, b ^ 8'h5A};
   endfunction

   initial begin
      int base;
      int waited;
      logic [7:0] chk;

      idle(3);
      check("rst_enable", 32'(enable), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_ack_valid", 32'(ack_valid), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_ack_data", 32'(ack_data), 32'd0);
      reset = 1'b1;
      idle(2);

      // single word good load
      send_byte(8'hA5);
      send_byte(8'h01);
      send_word(32'h20010005);
      check("l1_we", 32'(imem_we), 32'd1);
      check("l1_addr", 32'(imem_addr), 32'd0);
      check("l1_wdata", imem_wdata, 32'h20010005);
      idle(1);
      check("l1_we_pulse", 32'(imem_we), 32'd0);
      send_byte(8'h24);
      check_reply("l1", 8'h06);
      check("l1_enable", 32'(enable), 32'd1);
      check("l1_load_err", 32'(load_err), 32'd0);
      idle(1);
      check("l1_ack_pulse", 32'(ack_valid), 32'd0);

      // bad checksum; header also preempts the running CPU
      base = we_count;
      send_byte(8'hA5);
      check("bad_preempt", 32'(enable), 32'd0);
      send_byte(8'h01);
      send_word(32'h20010005);
      send_byte(8'h25);
      check_reply("bad", 8'h15);
      check("bad_load_err", 32'(load_err), 32'd1);
      check("bad_enable", 32'(enable), 32'd0);
      check("bad_wrote", 32'(we_count - base), 32'd1);

      // illegal counts
      base = we_count;
      send_byte(8'hA5);
      check("n0_err_clr", 32'(load_err), 32'd0);
      send_byte(8'h00);
      check_reply("n0", 8'h15);
      check("n0_load_err", 32'(load_err), 32'd1);
      send_byte(8'h5A);
      check("n0_idle_run", 32'(enable), 32'd1);
      send_byte(8'hA5);
      check("n41_stop", 32'(enable), 32'd0);
      send_byte(8'h41);
      check_reply("n41", 8'h15);
      send_byte(8'h5A);
      check("n41_idle_run", 32'(enable), 32'd1);
      check("n_no_write", 32'(we_count - base), 32'd0);

      // run / stop
      send_byte(8'h3C);
      check("stop", 32'(enable), 32'd0);
      send_byte(8'h77);
      check("ignored", 32'(enable), 32'd0);
      send_byte(8'h5A);
      check("run", 32'(enable), 32'd1);
      send_byte(8'hA5);
      check("run_preempt", 32'(enable), 32'd0);
      send_byte(8'h00);
      check_reply("close", 8'h15);

      // timeout mid frame
      base = we_count;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      waited = 0;
      while (!ack_valid && waited < 3 * TMO) begin
         idle(1);
         waited++;
      end
      check("tmo_cycles", 32'(waited), 32'(TMO));
      check_reply("tmo", 8'h15);
      check("tmo_load_err", 32'(load_err), 32'd1);
      check("tmo_no_write", 32'(we_count - base), 32'd0);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_word(32'hDEADBEEF);
      check("tmo_re_addr", 32'(imem_addr), 32'd0);
      check("tmo_re_wdata", imem_wdata, 32'hDEADBEEF);
      send_byte(8'h22);
      check_reply("tmo_re", 8'h06);
      check("tmo_re_enable", 32'(enable), 32'd1);

      // full depth
      send_byte(8'hA5);
      send_byte(8'h40);
      chk = 8'h00;
      for (int i = 0; i < 64; i++) begin
         logic [31:0] w;
         w = pattern(i);
         chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send_word(w);
         check($sformatf("full_addr%0d", i), 32'(imem_addr), 32'(i));
         check($sformatf("full_wdata%0d", i), imem_wdata, w);
      end
      send_byte(chk);
      check_reply("full", 8'h06);
      check("full_enable", 32'(enable), 32'd1);

      // reset after word 10
      send_byte(8'hA5);
      send_byte(8'h40);
      for (int i = 0; i <= 10; i++) begin
         send_word(pattern(i));
      end
      check("mid_addr10", 32'(imem_addr), 32'd10);
      base = ack_count;
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("mid_rst_addr", 32'(imem_addr), 32'd0);
      check("mid_rst_wdata", imem_wdata, 32'd0);
      check("mid_rst_we", 32'(imem_we), 32'd0);
      check("mid_rst_enable", 32'(enable), 32'd0);
      check("mid_rst_ack_data", 32'(ack_data), 32'd0);
      check("mid_rst_load_err", 32'(load_err), 32'd0);
      idle(3);
      reset = 1'b1;
      idle(2 * TMO);
      check("mid_no_reply", 32'(ack_count - base), 32'd0);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_word(32'h12345678);
      check("post_addr", 32'(imem_addr), 32'd0);
      check("post_wdata", imem_wdata, 32'h12345678);
      send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
      check_reply("post", 8'h06);
      check("post_enable", 32'(enable), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
